// File: rtl/kf8237_transfer_sequencer.sv
// kf8237_transfer_sequencer: HRQ/HLDA handshake and 8237 SI..S4 word sequencing for the KF8237 DMA core
module kf8237_transfer_sequencer #(
  parameter bit          COMPRESSED_TIMING = 1'b0,
  parameter int unsigned WAIT_LIMIT        = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       master_clear,
  input  logic [3:0] encoded_dma,
  input  logic [7:0] transfer_mode,
  input  logic       hold_acknowledge,
  input  logic       ready,
  input  logic       terminal_count,
  input  logic       external_end_of_process,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge_internal,
  output logic       next_word,
  output logic       end_of_process,
  output logic [1:0] dma_rotate,
  output logic [2:0] transfer_state
);
  typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4, SC} state_t;
  state_t      state;
  logic [1:0]  ch, mode, req_ch, req_mode;
  logic [15:0] wait_cnt;
  logic        eop_now, done, wait_expired;
  always_comb begin
    req_ch       = encoded_dma[0] ? 2'd0 : encoded_dma[1] ? 2'd1 : encoded_dma[2] ? 2'd2 : 2'd3;
    req_mode     = transfer_mode[{req_ch, 1'b0} +: 2];
    eop_now      = terminal_count | external_end_of_process;
    done         = eop_now | !hold_acknowledge | (mode == 2'b01) | ((mode == 2'b00) & !encoded_dma[ch]);
    wait_expired = (WAIT_LIMIT != 0) && (32'(wait_cnt) >= WAIT_LIMIT);
  end
  assign transfer_state = state;
  always_ff @(posedge clock)
    if (reset || master_clear) begin
      state                    <= SI;
      hold_request             <= 1'b0;
      dma_acknowledge_internal <= 4'b0;
      next_word                <= 1'b0;
      end_of_process           <= 1'b0;
      dma_rotate               <= 2'b11;
      wait_cnt                 <= '0;
      ch                       <= 2'd0;
      mode                     <= 2'd0;
    end else begin
      next_word      <= 1'b0;
      end_of_process <= 1'b0;
      case (state)
        SI: if (|encoded_dma) begin
          state        <= S0;
          hold_request <= 1'b1;
        end
        S0: if (~|encoded_dma) begin
          state        <= SI;
          hold_request <= 1'b0;
        end else if (hold_acknowledge) begin
          ch                       <= req_ch;
          mode                     <= req_mode;
          state                    <= (req_mode == 2'b11) ? SC : S1;
          dma_acknowledge_internal <= 4'b1 << req_ch;
        end
        S1: state <= S2;
        S2: begin
          state     <= COMPRESSED_TIMING ? S4 : S3;
          next_word <= COMPRESSED_TIMING;
        end
        S3: if (ready) begin
          state     <= S4;
          next_word <= 1'b1;
        end else begin
          state    <= SW;
          wait_cnt <= 16'd1;
        end
        SW: if (ready || wait_expired) begin
          state     <= S4;
          next_word <= 1'b1;
        end else
          wait_cnt <= wait_cnt + 16'd1;
        // EOP is reported the cycle after S4, alongside the return to SI
        S4: begin
          end_of_process <= eop_now;
          if (done) begin
            state                    <= SI;
            hold_request             <= 1'b0;
            dma_acknowledge_internal <= 4'b0;
            dma_rotate               <= ch;
          end else
            state <= S2;
        end
        SC: if (!encoded_dma[ch]) begin
          state                    <= SI;
          hold_request             <= 1'b0;
          dma_acknowledge_internal <= 4'b0;
          dma_rotate               <= ch;
        end
      endcase
    end
endmodule
